prog_loader: RTL and testbench
==============================

PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter BASE_ADDR, default 1: instruction-memory word address of the first loaded word.
REQ-002 Parameter DEPTH, default 1024: instruction-memory depth in 16-bit words.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  one-cycle pulse that arms a load.
REQ-006 rx_data  input  8  byte-stream data.
REQ-007 rx_valid  input  1  rx_data valid.
REQ-008 rx_ready  output  1  loader accepts a byte; a transfer occurs when rx_valid and rx_ready are both high on a rising edge.
REQ-009 wr_en  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 wr_addr  output  16  instruction-memory word address.
REQ-011 wr_data  output  16  instruction word.
REQ-012 cpu_hold  output  1  holds the CPU in reset while high.
REQ-013 done  output  1  last load completed with a good checksum.
REQ-014 error  output  1  last load failed.
REQ-015 words_loaded  output  16  words written in the current or last load.

Function
REQ-016 Stream format, in order:
- LEN_HI, LEN_LO: N = word count, big-endian.
- N words, each sent high byte then low byte.
- One checksum byte.
REQ-017 Checksum rule: the 8-bit sum, modulo 256, of all word bytes plus the checksum byte equals 0x00; length bytes are excluded.
REQ-018 States: IDLE, LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, CHK, DONE, ERROR.
REQ-019 IDLE, DONE and ERROR: on start, go to LEN_HI and set cpu_hold=1, done=0, error=0, words_loaded=0; start is ignored in every other state.
REQ-020 rx_ready=1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO and CHK; each state advances only on a transfer, and any number of rx_valid gaps is tolerated.
REQ-021 LEN_LO exit:
- N=0: go to CHK.
- N > DEPTH-BASE_ADDR: go to ERROR with no writes.
- Otherwise: go to DAT_HI.
REQ-022 DAT_HI latches wr_data[15:8]; DAT_LO latches wr_data[7:0] and goes to WRITE.
REQ-023 WRITE lasts exactly one cycle:
- wr_en=1, wr_addr=BASE_ADDR+words_loaded.
- words_loaded increments at that edge.
- Next state is CHK if words_loaded+1==N, else DAT_HI.
REQ-024 CHK on transfer: running sum plus checksum byte equal to 0x00 -> DONE and cpu_hold=0; otherwise -> ERROR with cpu_hold held at 1.
REQ-025 wr_en is 0 in every state except WRITE, and wr_addr/wr_data hold their last values while wr_en=0.
REQ-026 Minimum throughput is 3 cycles per word; a load of N words completes in at least 3N+4 cycles after start.
REQ-027 The address never exceeds BASE_ADDR+N-1 and never wraps; this is guaranteed by the check in REQ-021.

Reset
REQ-028 Asserting reset_n=0 forces, asynchronously and at any point mid-load:
- state IDLE.
- rx_ready=0, wr_en=0, wr_addr=0, wr_data=0.
- cpu_hold=0, done=0, error=0, words_loaded=0.
- checksum accumulator 0.
REQ-029 A load interrupted by reset is abandoned, and memory contents already written are left as written.

Structure
REQ-030 A shared package holds the state encoding and the stream-format constants: header length 2 bytes, checksum length 1 byte.
REQ-031 Single module, no sub-modules; byte assembly, counter and FSM are inline.

Verification
REQ-032 Nominal load:
- Stimulus: start, then bytes 00 03 00 8D 00 04 E0 8E 01.
- Response: wr_en at addresses 1/2/3 with data 008D/0004/E08E, then done=1, error=0, cpu_hold=0, words_loaded=3.
REQ-033 Bad checksum:
- Stimulus: the same stream with final byte 02.
- Response: 3 writes, then error=1, done=0, cpu_hold=1.
REQ-034 Length bounds, with BASE_ADDR=1 and DEPTH=1024:
- Length 03 FF is accepted.
- Length 04 00 gives error=1 immediately after LEN_LO, with no wr_en pulse.
REQ-035 Zero length:
- Stimulus: bytes 00 00 00.
- Response: done=1, no writes, words_loaded=0.
REQ-036 Flow control:
- Random rx_valid gaps plus a start pulse in DAT_LO give results identical to REQ-032, with start ignored.
- rx_ready must be 0 in the WRITE cycle.
REQ-037 Reset mid-load:
- Stimulus: reset_n low after the second data word.
- Response: all outputs go to reset values immediately, and a fresh start and REQ-032 stream then loads correctly.

Source files
------------

// File: rtl/prog_loader_pkg.sv
// rtl/prog_loader_pkg.sv - shared state encoding and stream-format constants for prog_loader
package prog_loader_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_LEN_HI = 4'd1,
        ST_LEN_LO = 4'd2,
        ST_DAT_HI = 4'd3,
        ST_DAT_LO = 4'd4,
        ST_WRITE  = 4'd5,
        ST_CHK    = 4'd6,
        ST_DONE   = 4'd7,
        ST_ERROR  = 4'd8
    } state_t;

    // Header is LEN_HI, LEN_LO; trailer is one checksum byte.
    localparam int HDR_LEN = 2;
    localparam int CHK_LEN = 1;

endpackage

// File: rtl/prog_loader_if.sv
// rtl/prog_loader_if.sv - byte stream in and instruction-memory write port of prog_loader
interface prog_loader_if;

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;

    // Loader side: consumes the byte stream, drives the memory write port.
    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    // Environment side: produces the byte stream, observes the memory writes.
    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - byte-stream program loader writing 16-bit words into instruction memory
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int BASE_ADDR = 1,
    parameter int DEPTH     = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    prog_loader_if.slave      bus,
    output logic              cpu_hold,
    output logic              done,
    output logic              error,
    output logic [15:0]       words_loaded
);

    // Largest word count that fits between BASE_ADDR and the top of memory.
    localparam logic [16:0] MAX_WORDS = 17'(DEPTH - BASE_ADDR);
    localparam logic [15:0] BASE      = 16'(BASE_ADDR);

    state_t      state;
    state_t      next_state;
    logic [7:0]  len_hi;
    logic [15:0] len;
    logic [7:0]  data_hi;
    logic [7:0]  sum;

    logic        xfer;
    logic [15:0] len_word;
    logic        len_too_big;
    logic        last_word;
    logic [7:0]  chk_sum;

    assign xfer        = bus.rx_valid && bus.rx_ready;
    assign len_word    = {len_hi, bus.rx_data};
    assign len_too_big = {1'b0, len_word} > MAX_WORDS;
    assign last_word   = (words_loaded + 16'd1) == len;
    assign chk_sum     = sum + bus.rx_data;

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode plus the per-state handshake and write strobe.
    always_comb begin
        next_state   = state;
        bus.rx_ready = 1'b0;
        bus.wr_en    = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start) next_state = ST_LEN_HI;
            end
            ST_LEN_HI: begin
                bus.rx_ready = 1'b1;
                if (xfer) next_state = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                bus.rx_ready = 1'b1;
                if (xfer) begin
                    if (len_word == 16'd0)  next_state = ST_CHK;
                    else if (len_too_big)   next_state = ST_ERROR;
                    else                    next_state = ST_DAT_HI;
                end
            end
            ST_DAT_HI: begin
                bus.rx_ready = 1'b1;
                if (xfer) next_state = ST_DAT_LO;
            end
            ST_DAT_LO: begin
                bus.rx_ready = 1'b1;
                if (xfer) next_state = ST_WRITE;
            end
            ST_WRITE: begin
                bus.wr_en  = 1'b1;
                next_state = last_word ? ST_CHK : ST_DAT_HI;
            end
            ST_CHK: begin
                bus.rx_ready = 1'b1;
                if (xfer) next_state = (chk_sum == 8'h00) ? ST_DONE : ST_ERROR;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    // Datapath: length capture, word assembly, checksum, counter and status flags.
    // wr_data is loaded whole at DAT_LO so the write port stays stable between strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            len_hi       <= 8'h00;
            len          <= 16'h0000;
            data_hi      <= 8'h00;
            sum          <= 8'h00;
            bus.wr_addr  <= 16'h0000;
            bus.wr_data  <= 16'h0000;
            cpu_hold     <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        cpu_hold     <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= 16'h0000;
                        sum          <= 8'h00;
                    end
                end
                ST_LEN_HI: begin
                    if (xfer) len_hi <= bus.rx_data;
                end
                ST_LEN_LO: begin
                    if (xfer) begin
                        len <= len_word;
                        if (len_word != 16'd0 && len_too_big) error <= 1'b1;
                    end
                end
                ST_DAT_HI: begin
                    if (xfer) begin
                        data_hi <= bus.rx_data;
                        sum     <= sum + bus.rx_data;
                    end
                end
                ST_DAT_LO: begin
                    if (xfer) begin
                        bus.wr_data <= {data_hi, bus.rx_data};
                        bus.wr_addr <= BASE + words_loaded;
                        sum         <= sum + bus.rx_data;
                    end
                end
                ST_WRITE: begin
                    words_loaded <= words_loaded + 16'd1;
                end
                ST_CHK: begin
                    if (xfer) begin
                        if (chk_sum == 8'h00) begin
                            done     <= 1'b1;
                            cpu_hold <= 1'b0;
                        end else begin
                            error    <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - directed self-checking bench for prog_loader with write scoreboard
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] words_loaded;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    logic [15:0] wq[$];

    prog_loader_if bus ();

    prog_loader #(.BASE_ADDR(1), .DEPTH(1024)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .bus          (bus),
        .cpu_hold     (cpu_hold),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every write strobe pops the next expected {addr, data}.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("wr_addr", {16'd0, bus.wr_addr}, {16'd0, e[31:16]});
                check("wr_data", {16'd0, bus.wr_data}, {16'd0, e[15:0]});
                check("rx_ready_in_write", {31'd0, bus.rx_ready}, 32'd0);
            end
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int t;
        t = 0;
        if (gaps) begin
            int n;
            n = $urandom_range(0, 3);
            repeat (n) begin @(posedge clk); #1; end
        end
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.rx_ready === 1'b1) break;
            t++;
            if (t > 50) begin
                check("rx_ready_timeout", 32'd0, 32'd1);
                bus.rx_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    // Streams a load of wq[0..n-1]; start_at selects a word whose DAT_LO wait gets a stray start.
    task automatic run_load(input int n, input bit bad, input bit gaps, input int start_at);
        logic [7:0]  s;
        logic [7:0]  chk;
        logic [15:0] nn;
        s  = 8'h00;
        nn = 16'(n);
        pulse_start();
        send_byte(nn[15:8], gaps);
        send_byte(nn[7:0], gaps);
        for (int i = 0; i < n; i++) begin
            logic [15:0] w;
            w = wq[i];
            exp_q.push_back({16'(1 + i), w});
            s = s + w[15:8] + w[7:0];
            send_byte(w[15:8], gaps);
            if (i == start_at) pulse_start();
            send_byte(w[7:0], gaps);
        end
        chk = 8'h00 - s;
        if (bad) chk = chk + 8'h01;
        send_byte(chk, gaps);
    endtask

    task automatic finish_check(input string tag, input logic d, input logic e, input logic h,
                                input logic [15:0] wl);
        int t;
        t = 0;
        while (!(done === 1'b1 || error === 1'b1) && t < 20) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done"}, {31'd0, done}, {31'd0, d});
        check({tag, "_error"}, {31'd0, error}, {31'd0, e});
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, {31'd0, h});
        check({tag, "_words"}, {16'd0, words_loaded}, {16'd0, wl});
        check({tag, "_pending_writes"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    task automatic load_nominal_words();
        wq.delete();
        wq.push_back(16'h008D);
        wq.push_back(16'h0004);
        wq.push_back(16'hE08E);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_ready"}, {31'd0, bus.rx_ready}, 32'd0);
        check({tag, "_wr_en"}, {31'd0, bus.wr_en}, 32'd0);
        check({tag, "_wr_addr"}, {16'd0, bus.wr_addr}, 32'd0);
        check({tag, "_wr_data"}, {16'd0, bus.wr_data}, 32'd0);
        check({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_error"}, {31'd0, error}, 32'd0);
        check({tag, "_words"}, {16'd0, words_loaded}, 32'd0);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;

        // Reset state
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Nominal load: 00 03 00 8D 00 04 E0 8E 01
        load_nominal_words();
        run_load(3, 1'b0, 1'b0, -1);
        finish_check("nominal", 1'b1, 1'b0, 1'b0, 16'd3);

        // Bad checksum: final byte 02
        run_load(3, 1'b1, 1'b0, -1);
        finish_check("bad_chk", 1'b0, 1'b1, 1'b1, 16'd3);

        // Zero length: 00 00 00
        wq.delete();
        run_load(0, 1'b0, 1'b0, -1);
        finish_check("zero_len", 1'b1, 1'b0, 1'b0, 16'd0);

        // Length 04 00 exceeds DEPTH-BASE_ADDR: error right after LEN_LO, no writes
        pulse_start();
        send_byte(8'h04, 1'b0);
        send_byte(8'h00, 1'b0);
        @(negedge clk);
        check("too_long_error", {31'd0, error}, 32'd1);
        check("too_long_done", {31'd0, done}, 32'd0);
        check("too_long_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        check("too_long_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        repeat (3) @(posedge clk);
        #1;

        // Length 03 FF is the largest accepted load
        wq.delete();
        for (int i = 0; i < 1023; i++) wq.push_back(16'((i * 16'h0137) ^ 16'h5A00));
        run_load(1023, 1'b0, 1'b0, -1);
        finish_check("max_len", 1'b1, 1'b0, 1'b0, 16'd1023);

        // Flow control: random gaps and a stray start while waiting in DAT_LO
        load_nominal_words();
        run_load(3, 1'b0, 1'b1, 1);
        finish_check("flow", 1'b1, 1'b0, 1'b0, 16'd3);

        // Reset mid-load after the second data word
        pulse_start();
        send_byte(8'h00, 1'b0);
        send_byte(8'h03, 1'b0);
        for (int i = 0; i < 2; i++) begin
            exp_q.push_back({16'(1 + i), wq[i]});
            send_byte(wq[i][15:8], 1'b0);
            send_byte(wq[i][7:0], 1'b0);
        end
        @(posedge clk); #1;
        @(posedge clk); #3;
        check("midload_writes_seen", exp_q.size(), 32'd0);
        check("midload_words_before_reset", {16'd0, words_loaded}, 32'd2);
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midload_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        run_load(3, 1'b0, 1'b0, -1);
        finish_check("after_reset", 1'b1, 1'b0, 1'b0, 16'd3);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        check("global_timeout", 32'd1, 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "FAIL global_timeout reached");
    end

endmodule
